// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a w x h rectangle from the character RAM into the frame buffer,
// one pixel per clock, skipping key-coloured pixels and clipping to the visible screen.
module sprite_blitter #(
   parameter int                FB_W   = 240,
   parameter int                FB_H   = 160,
   parameter int                ADDR_W = 19,
   parameter int                DATA_W = 24,
   parameter logic [DATA_W-1:0] KEY    = 24'hFF00FF
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] src_stride,
   input  logic [7:0]        spr_w,
   input  logic [7:0]        spr_h,
   input  logic [9:0]        dst_x,
   input  logic [9:0]        dst_y,
   output logic [ADDR_W-1:0] char_read_address,
   input  logic [DATA_W-1:0] char_data,
   output logic [ADDR_W-1:0] fb_write_address,
   output logic [DATA_W-1:0] fb_data,
   output logic              fb_we,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);
   localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [9:0]        FB_W_10 = 10'(FB_W);
   localparam logic [9:0]        FB_H_10 = 10'(FB_H);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   state_t state_r;
   state_t state_s;

   logic [7:0]        w_r;
   logic [7:0]        h_r;
   logic [ADDR_W-1:0] stride_r;
   logic [9:0]        dst_x_r;
   logic [9:0]        dst_y_r;
   logic [7:0]        col_r;
   logic [7:0]        row_r;
   logic [ADDR_W-1:0] row_base_r;
   logic [ADDR_W-1:0] src_ptr_r;
   logic [ADDR_W-1:0] dst_row_addr_r;

   logic              valid_r;
   logic [10:0]       sx_r;
   logic [10:0]       sy_r;
   logic [ADDR_W-1:0] fb_addr_r;

   logic              last_col_s;
   logic              last_row_s;
   logic              zero_size_s;
   logic [10:0]       cur_sx_s;
   logic [10:0]       cur_sy_s;
   logic [ADDR_W-1:0] cur_fb_addr_s;

   // dst_y * FB_W in modular ADDR_W arithmetic; a negative row start wraps and is
   // brought back on screen by the per-row FB_W increments.
   function automatic logic [ADDR_W-1:0] row_offset(input logic [9:0] y);
      logic [ADDR_W-1:0] y_ext;
      y_ext = {{(ADDR_W-10){y[9]}}, y};
      return y_ext * FB_W_A;
   endfunction

   function automatic logic in_screen(input logic [10:0] x, input logic [10:0] y);
      return !x[10] && (x[9:0] < FB_W_10) && !y[10] && (y[9:0] < FB_H_10);
   endfunction

   assign last_col_s    = (col_r == (w_r - 8'd1));
   assign last_row_s    = (row_r == (h_r - 8'd1));
   assign zero_size_s   = (spr_w == 8'd0) || (spr_h == 8'd0);
   assign cur_sx_s      = {dst_x_r[9], dst_x_r} + {3'b000, col_r};
   assign cur_sy_s      = {dst_y_r[9], dst_y_r} + {3'b000, row_r};
   assign cur_fb_addr_s = dst_row_addr_r + {{(ADDR_W-11){cur_sx_s[10]}}, cur_sx_s};

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (zero_size_s) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_col_s && last_row_s) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: state_s = ST_DONE;
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Command latch and raster walk; read pointers only advance while reading.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         w_r            <= 8'd0;
         h_r            <= 8'd0;
         stride_r       <= {ADDR_W{1'b0}};
         dst_x_r        <= 10'd0;
         dst_y_r        <= 10'd0;
         col_r          <= 8'd0;
         row_r          <= 8'd0;
         row_base_r     <= {ADDR_W{1'b0}};
         src_ptr_r      <= {ADDR_W{1'b0}};
         dst_row_addr_r <= {ADDR_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  w_r            <= spr_w;
                  h_r            <= spr_h;
                  stride_r       <= src_stride;
                  dst_x_r        <= dst_x;
                  dst_y_r        <= dst_y;
                  col_r          <= 8'd0;
                  row_r          <= 8'd0;
                  dst_row_addr_r <= row_offset(dst_y);
                  if (!zero_size_s) begin
                     row_base_r <= src_base;
                     src_ptr_r  <= src_base;
                  end
               end
            end
            ST_RUN: begin
               if (last_col_s) begin
                  if (!last_row_s) begin
                     col_r          <= 8'd0;
                     row_r          <= row_r + 8'd1;
                     row_base_r     <= row_base_r + stride_r;
                     src_ptr_r      <= row_base_r + stride_r;
                     dst_row_addr_r <= dst_row_addr_r + FB_W_A;
                  end
               end else begin
                  col_r     <= col_r + 8'd1;
                  src_ptr_r <= src_ptr_r + ONE_A;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Stage register pairing each read with its screen position, used when data returns.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         valid_r   <= 1'b0;
         sx_r      <= 11'd0;
         sy_r      <= 11'd0;
         fb_addr_r <= {ADDR_W{1'b0}};
      end else begin
         valid_r <= (state_r == ST_RUN);
         if (state_r == ST_RUN) begin
            sx_r <= cur_sx_s;
            sy_r <= cur_sy_s;
            if (in_screen(cur_sx_s, cur_sy_s)) begin
               fb_addr_r <= cur_fb_addr_s;
            end
         end
      end
   end

   assign char_read_address = src_ptr_r;
   assign fb_write_address  = fb_addr_r;
   assign fb_data           = valid_r ? char_data : {DATA_W{1'b0}};
   assign fb_we             = valid_r && in_screen(sx_r, sy_r) && (char_data != KEY);
   assign busy              = (state_r == ST_RUN) || (state_r == ST_DRAIN);
   assign done              = (state_r == ST_DONE);

endmodule
